// File: rtl/bb_queue_ctrl.sv
// ---------------------------------------------------------------------------
// bb_queue_ctrl
//   Control for a 64-entry circular basic-block queue. Slots are allocated in
//   order at wr_ptr and retired in order from rd_ptr. A branch-mispredict
//   flush keeps the slot at flush_ptr and kills every younger slot.
//
//   Ports
//     clk, rst        rising-edge clock, synchronous active-high reset
//     alloc_vld       allocate one slot at wr_ptr (dropped by a same-cycle flush)
//     alloc_rdy       count < 64
//     wr_ptr          next slot to allocate
//     retire_vld      retire the oldest slot at rd_ptr
//     rd_ptr          oldest valid slot (equals wr_ptr when empty)
//     flush_vld       mispredict flush request
//     flush_ptr       slot of the mispredicted branch; kept, younger slots killed
//     valid_vec       per-slot valid bits
//     count           number of valid slots, 0..64
//     full, empty     count == 64 / count == 0
//     kill_vec        one-cycle pulse of the slots removed by the last flush
//     flush_cnt       (only with BBQ_FLUSH_STATS_EN) saturating count of
//                     accepted flushes
//
//   Build option: define BBQ_FLUSH_STATS_EN to add the flush_cnt output.
// ---------------------------------------------------------------------------
module bb_queue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_vld,
    output logic        alloc_rdy,
    output logic [5:0]  wr_ptr,
    input  logic        retire_vld,
    output logic [5:0]  rd_ptr,
    input  logic        flush_vld,
    input  logic [5:0]  flush_ptr,
    output logic [63:0] valid_vec,
    output logic [6:0]  count,
    output logic        full,
    output logic        empty,
    output logic [63:0] kill_vec
`ifdef BBQ_FLUSH_STATS_EN
    ,
    output logic [15:0] flush_cnt
`endif
);

    logic        flush_acc;
    logic        retire_acc;
    logic        alloc_acc;
    logic [5:0]  wr_last;
    logic [5:0]  keep_span;
    logic [6:0]  flush_count;
    logic [63:0] kill_set;
    logic [63:0] valid_nxt;
    logic [5:0]  wr_nxt;
    logic [5:0]  rd_nxt;
    logic [6:0]  count_nxt;

    // Status flags come straight from the registered count.
    assign full      = (count == 7'd64);
    assign empty     = (count == 7'd0);
    assign alloc_rdy = ~full;

    assign flush_acc  = flush_vld & valid_vec[flush_ptr];
    assign retire_acc = retire_vld & ~empty;
    // When full, an alloc still goes through if a retire frees the same slot
    // this cycle (wr_ptr == rd_ptr when full).
    assign alloc_acc  = alloc_vld & (alloc_rdy | retire_acc) & ~flush_acc;

    assign wr_last     = wr_ptr - 6'd1;
    assign keep_span   = flush_ptr - rd_ptr;
    assign flush_count = {1'b0, keep_span} + 7'd1;

    // Slots strictly younger than flush_ptr, up to the youngest allocated
    // slot. When flush_ptr is the youngest slot the set is empty, which also
    // covers a full queue flushed at wr_ptr-1.
    always_comb begin
        kill_set = '0;
        for (int s = 0; s < 64; s++) begin
            if (flush_ptr < wr_last) begin
                kill_set[s] = (7'(s) > {1'b0, flush_ptr}) && (7'(s) <= {1'b0, wr_last});
            end else if (flush_ptr > wr_last) begin
                kill_set[s] = (7'(s) > {1'b0, flush_ptr}) || (7'(s) <= {1'b0, wr_last});
            end
        end
    end

    // Retire clears before alloc sets so that alloc+retire on a full queue
    // (same slot) leaves the slot valid.
    always_comb begin
        valid_nxt = valid_vec;
        if (flush_acc) begin
            valid_nxt = valid_nxt & ~kill_set;
        end
        if (retire_acc) begin
            valid_nxt[rd_ptr] = 1'b0;
        end
        if (alloc_acc) begin
            valid_nxt[wr_ptr] = 1'b1;
        end
    end

    always_comb begin
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        count_nxt = count;
        if (flush_acc) begin
            wr_nxt    = flush_ptr + 6'd1;
            count_nxt = flush_count - {6'd0, retire_acc};
        end else begin
            if (alloc_acc) begin
                wr_nxt = wr_ptr + 6'd1;
            end
            count_nxt = count + {6'd0, alloc_acc} - {6'd0, retire_acc};
        end
        if (retire_acc) begin
            rd_nxt = rd_ptr + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_vec <= '0;
            kill_vec  <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            valid_vec <= valid_nxt;
            kill_vec  <= flush_acc ? kill_set : 64'd0;
        end
    end

`ifdef BBQ_FLUSH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (flush_acc && (flush_cnt != 16'hFFFF)) begin
            flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bb_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bb_queue_ctrl
//   Directed scenarios plus randomized traffic for bb_queue_ctrl. The
//   reference model keeps the queue as an ordered list of slot numbers
//   (oldest first) and the next allocation slot.
// ---------------------------------------------------------------------------
module tb_bb_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_vld = 1'b0;
    logic        retire_vld = 1'b0;
    logic        flush_vld = 1'b0;
    logic [5:0]  flush_ptr = '0;
    logic        alloc_rdy;
    logic [5:0]  wr_ptr;
    logic [5:0]  rd_ptr;
    logic [63:0] valid_vec;
    logic [6:0]  count;
    logic        full;
    logic        empty;
    logic [63:0] kill_vec;
`ifdef BBQ_FLUSH_STATS_EN
    logic [15:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    bb_queue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_vld  (alloc_vld),
        .alloc_rdy  (alloc_rdy),
        .wr_ptr     (wr_ptr),
        .retire_vld (retire_vld),
        .rd_ptr     (rd_ptr),
        .flush_vld  (flush_vld),
        .flush_ptr  (flush_ptr),
        .valid_vec  (valid_vec),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .kill_vec   (kill_vec)
`ifdef BBQ_FLUSH_STATS_EN
        ,
        .flush_cnt  (flush_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: ordered list of live slots, next alloc slot.
    int          mq[$];
    int          m_wr = 0;
    logic [63:0] m_kill = '0;
    int          m_fcnt = 0;

    function automatic int m_rd();
        return (mq.size() > 0) ? mq[0] : m_wr;
    endfunction

    function automatic logic [63:0] m_valid();
        logic [63:0] v = '0;
        foreach (mq[i]) v[mq[i]] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input bit a, input bit r, input bit f, input int fp, input bit rs);
        int idx;
        bit ra;
        bit aa;
        m_kill = '0;
        if (rs) begin
            mq.delete();
            m_wr = 0;
            m_fcnt = 0;
            return;
        end
        idx = -1;
        if (f) foreach (mq[i]) if (mq[i] == fp) idx = i;
        ra = r && (mq.size() > 0);
        aa = a && ((mq.size() < 64) || ra) && (idx < 0);
        if (idx >= 0) begin
            while (mq.size() > idx + 1) begin
                m_kill[mq[mq.size()-1]] = 1'b1;
                void'(mq.pop_back());
            end
            m_wr = (fp + 1) % 64;
            if (m_fcnt < 65535) m_fcnt++;
        end
        if (ra) void'(mq.pop_front());
        if (aa) begin
            mq.push_back(m_wr);
            m_wr = (m_wr + 1) % 64;
        end
    endtask

    // One clock of stimulus; the model follows the same inputs.
    task automatic step(input bit a, input bit r, input bit f, input int fp);
        alloc_vld  = a;
        retire_vld = r;
        flush_vld  = f;
        flush_ptr  = 6'(fp);
        @(posedge clk);
        model_step(a, r, f, fp, rst);
        #1;
        alloc_vld  = 1'b0;
        retire_vld = 1'b0;
        flush_vld  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset asserted together with every request: reset must win.
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 0);
        rst = 1'b0;
        vectors++; if (wr_ptr !== 6'd0) begin miscompares++; $display("FAIL reset_wr_ptr got=%0d exp=0", wr_ptr); end
        vectors++; if (rd_ptr !== 6'd0) begin miscompares++; $display("FAIL reset_rd_ptr got=%0d exp=0", rd_ptr); end
        vectors++; if (count !== 7'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (valid_vec !== 64'd0) begin miscompares++; $display("FAIL reset_valid got=%h exp=0", valid_vec); end
        vectors++; if (kill_vec !== 64'd0) begin miscompares++; $display("FAIL reset_kill got=%h exp=0", kill_vec); end
        vectors++; if ({empty, full, alloc_rdy} !== 3'b101) begin miscompares++; $display("FAIL reset_flags got=%b exp=101", {empty, full, alloc_rdy}); end
`ifdef BBQ_FLUSH_STATS_EN
        vectors++; if (flush_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
`endif
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 0);
        vectors++; if ({full, alloc_rdy, empty} !== 3'b100) begin miscompares++; $display("FAIL fill_flags got=%b exp=100", {full, alloc_rdy, empty}); end
        vectors++; if (count !== 7'd64) begin miscompares++; $display("FAIL fill_count got=%0d exp=64", count); end
        vectors++; if (wr_ptr !== 6'd0) begin miscompares++; $display("FAIL fill_wr_ptr got=%0d exp=0", wr_ptr); end
        vectors++; if (valid_vec !== {64{1'b1}}) begin miscompares++; $display("FAIL fill_valid got=%h exp=all ones", valid_vec); end
        step(1'b1, 1'b0, 1'b0, 0);
        vectors++; if (count !== 7'd64) begin miscompares++; $display("FAIL alloc_full_count got=%0d exp=64", count); end
        vectors++; if (wr_ptr !== 6'd0) begin miscompares++; $display("FAIL alloc_full_wr_ptr got=%0d exp=0", wr_ptr); end
        // Flush at the youngest slot of a full queue kills nothing.
        step(1'b0, 1'b0, 1'b1, 63);
        vectors++; if (kill_vec !== 64'd0) begin miscompares++; $display("FAIL full_flush_kill got=%h exp=0", kill_vec); end
        vectors++; if (count !== 7'd64) begin miscompares++; $display("FAIL full_flush_count got=%0d exp=64", count); end
        vectors++; if (wr_ptr !== 6'd0) begin miscompares++; $display("FAIL full_flush_wr_ptr got=%0d exp=0", wr_ptr); end
    endtask

    task automatic test_flush_basic();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 4);
        vectors++; if (kill_vec !== 64'h3E0) begin miscompares++; $display("FAIL flush_kill got=%h exp=3e0", kill_vec); end
        vectors++; if (wr_ptr !== 6'd5) begin miscompares++; $display("FAIL flush_wr_ptr got=%0d exp=5", wr_ptr); end
        vectors++; if (count !== 7'd5) begin miscompares++; $display("FAIL flush_count got=%0d exp=5", count); end
        vectors++; if (valid_vec !== 64'h1F) begin miscompares++; $display("FAIL flush_valid got=%h exp=1f", valid_vec); end
        step(1'b0, 1'b0, 1'b0, 0);
        vectors++; if (kill_vec !== 64'd0) begin miscompares++; $display("FAIL flush_pulse_len got=%h exp=0", kill_vec); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0);
        vectors++; if ({rd_ptr, wr_ptr} !== {6'd60, 6'd6}) begin miscompares++; $display("FAIL wrap_setup got=%0d/%0d exp=60/6", rd_ptr, wr_ptr); end
        step(1'b0, 1'b0, 1'b1, 62);
        vectors++; if (kill_vec !== 64'h8000_0000_0000_003F) begin miscompares++; $display("FAIL wrap_kill got=%h exp=800000000000003f", kill_vec); end
        vectors++; if (wr_ptr !== 6'd63) begin miscompares++; $display("FAIL wrap_wr_ptr got=%0d exp=63", wr_ptr); end
        vectors++; if (count !== 7'd3) begin miscompares++; $display("FAIL wrap_count got=%0d exp=3", count); end
        vectors++; if (valid_vec !== 64'h7000_0000_0000_0000) begin miscompares++; $display("FAIL wrap_valid got=%h exp=7000000000000000", valid_vec); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        vectors++; if (count !== 7'd64) begin miscompares++; $display("FAIL alloc_retire_full_count got=%0d exp=64", count); end
        vectors++; if ({rd_ptr, wr_ptr} !== {6'd1, 6'd1}) begin miscompares++; $display("FAIL alloc_retire_full_ptrs got=%0d/%0d exp=1/1", rd_ptr, wr_ptr); end
        vectors++; if (valid_vec !== {64{1'b1}}) begin miscompares++; $display("FAIL alloc_retire_full_valid got=%h exp=all ones", valid_vec); end
        step(1'b1, 1'b0, 1'b1, 20);
        vectors++; if (wr_ptr !== 6'd21) begin miscompares++; $display("FAIL flush_alloc_wr_ptr got=%0d exp=21", wr_ptr); end
        vectors++; if (count !== 7'd20) begin miscompares++; $display("FAIL flush_alloc_count got=%0d exp=20", count); end
        vectors++; if (kill_vec !== 64'hFFFF_FFFF_FFE0_0001) begin miscompares++; $display("FAIL flush_alloc_kill got=%h exp=ffffffffffe00001", kill_vec); end
        vectors++; if (valid_vec !== 64'h1F_FFFE) begin miscompares++; $display("FAIL flush_alloc_valid got=%h exp=1ffffe", valid_vec); end
    endtask

    task automatic test_invalid_flush();
`ifdef BBQ_FLUSH_STATS_EN
        logic [15:0] cnt_before;
`endif
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 3);
`ifdef BBQ_FLUSH_STATS_EN
        cnt_before = flush_cnt;
        vectors++; if (cnt_before !== 16'd1) begin miscompares++; $display("FAIL flush_cnt_inc got=%0d exp=1", cnt_before); end
`endif
        step(1'b0, 1'b0, 1'b1, 20);
        vectors++; if ({wr_ptr, count} !== {6'd4, 7'd4}) begin miscompares++; $display("FAIL bad_flush_state got=%0d/%0d exp=4/4", wr_ptr, count); end
        vectors++; if (valid_vec !== 64'hF) begin miscompares++; $display("FAIL bad_flush_valid got=%h exp=f", valid_vec); end
        vectors++; if (kill_vec !== 64'd0) begin miscompares++; $display("FAIL bad_flush_kill got=%h exp=0", kill_vec); end
`ifdef BBQ_FLUSH_STATS_EN
        vectors++; if (flush_cnt !== cnt_before) begin miscompares++; $display("FAIL bad_flush_cnt got=%0d exp=%0d", flush_cnt, cnt_before); end
`endif
    endtask

    task automatic test_flush_retire();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 0);
        vectors++; if ({empty, count} !== {1'b1, 7'd0}) begin miscompares++; $display("FAIL flush_retire_empty got=%b/%0d exp=1/0", empty, count); end
        vectors++; if ({rd_ptr, wr_ptr} !== {6'd1, 6'd1}) begin miscompares++; $display("FAIL flush_retire_ptrs got=%0d/%0d exp=1/1", rd_ptr, wr_ptr); end
        vectors++; if (kill_vec !== 64'h3FE) begin miscompares++; $display("FAIL flush_retire_kill got=%h exp=3fe", kill_vec); end
        vectors++; if (valid_vec !== 64'd0) begin miscompares++; $display("FAIL flush_retire_valid got=%h exp=0", valid_vec); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 3);
        rst = 1'b0;
        vectors++; if (kill_vec !== 64'd0) begin miscompares++; $display("FAIL rst_flush_kill got=%h exp=0", kill_vec); end
        vectors++; if ({wr_ptr, count} !== {6'd0, 7'd0}) begin miscompares++; $display("FAIL rst_flush_state got=%0d/%0d exp=0/0", wr_ptr, count); end
    endtask

    task automatic test_random();
        bit a, r, f;
        int fp;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            // Alternate alloc-heavy and retire-heavy phases to visit full and empty.
            if (((cyc / 400) % 2) == 0) begin
                a = ($urandom_range(99) < 85);
                r = ($urandom_range(99) < 30);
            end else begin
                a = ($urandom_range(99) < 30);
                r = ($urandom_range(99) < 85);
            end
            f = ($urandom_range(99) < 6);
            if ((mq.size() > 0) && ($urandom_range(3) != 0))
                fp = mq[$urandom_range(mq.size() - 1)];
            else
                fp = $urandom_range(63);
            rst = ($urandom_range(999) == 0);
            step(a, r, f, fp);
            rst = 1'b0;
            vectors++; if (wr_ptr !== 6'(m_wr)) begin miscompares++; $display("FAIL rnd_wr_ptr cyc=%0d got=%0d exp=%0d", cyc, wr_ptr, m_wr); end
            vectors++; if (rd_ptr !== 6'(m_rd())) begin miscompares++; $display("FAIL rnd_rd_ptr cyc=%0d got=%0d exp=%0d", cyc, rd_ptr, m_rd()); end
            vectors++; if (count !== 7'(mq.size())) begin miscompares++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
            vectors++; if (valid_vec !== m_valid()) begin miscompares++; $display("FAIL rnd_valid cyc=%0d got=%h exp=%h", cyc, valid_vec, m_valid()); end
            vectors++; if (kill_vec !== m_kill) begin miscompares++; $display("FAIL rnd_kill cyc=%0d got=%h exp=%h", cyc, kill_vec, m_kill); end
            vectors++; if ({full, empty, alloc_rdy} !== {mq.size() == 64, mq.size() == 0, mq.size() < 64}) begin
                miscompares++; $display("FAIL rnd_flags cyc=%0d got=%b size=%0d", cyc, {full, empty, alloc_rdy}, mq.size());
            end
`ifdef BBQ_FLUSH_STATS_EN
            vectors++; if (flush_cnt !== 16'(m_fcnt)) begin miscompares++; $display("FAIL rnd_flush_cnt cyc=%0d got=%0d exp=%0d", cyc, flush_cnt, m_fcnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_flush_basic();
        test_wrap();
        test_same_cycle();
        test_invalid_flush();
        test_flush_retire();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
